if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that feeds the IF/DE pipeline register consumed by the decode stage and hazard control unit. It generates the fetch PC and drives a one-outstanding-request instruction-memory handshake. It applies branch redirects, squashes fetched instructions on IFFlush, and replays the decode-stage instruction on IFFlushBack.

Parameters:
XLEN, 32, PC/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction presented to DE when IFValid is low

Ports:
CLK  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
IFFlush  in  1  squash the instruction being delivered to DE this cycle
IFFlushBack  in  1  DE instruction bubbled by hazard unit; refetch it
BranchRedirect  in  1  taken branch/jump resolved downstream
BranchTarget  in  XLEN  redirect address, word aligned
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address
imem_ready  in  1  memory accepts request when imem_req&imem_ready
imem_rvalid  in  1  response valid, exactly one cycle after acceptance
imem_rdata  in  XLEN  instruction word
IFValid  out  1  IF/DE register holds a live instruction
IFPC  out  XLEN  PC of IFInstr
IFInstr  out  XLEN  instruction to DE

Behaviour:
- Reset (async, while rst=1): state=BOOT, fetch_pc=RESET_PC, de_pc=RESET_PC, pending=0, drop=0, IFValid=0, IFPC=RESET_PC, IFInstr=NOP_INSTR, imem_req=0.
- FSM states:
  - BOOT: one cycle after rst falls, imem_req=0, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - REDIRECT: exactly one cycle. imem_req=1 at the new fetch_pc. The response to the pre-redirect request is discarded. Then go to FETCH.
- Acceptance at cycle t: rsp_pc<=fetch_pc and pending<=1. Response arrives at t+1. IF/DE register updates at the t+1 edge, so it is visible at t+2. Steady-state throughput is 1 instr/cycle with imem_ready=1.
- Next fetch_pc priority (highest first):
  1. BranchRedirect: BranchTarget.
  2. IFFlushBack: de_pc.
  3. Accepted request: fetch_pc+4, mod 2^XLEN, so 0xFFFFFFFC wraps to 0.
  4. Otherwise: hold.
- Either redirect source (BranchRedirect or IFFlushBack) sets drop for the request accepted in that cycle and moves to REDIRECT. A response arriving in the redirect cycle is also discarded.
- IF/DE register update when imem_rvalid & ~drop & ~IFFlush & ~IFFlushBack & ~BranchRedirect: IFValid<=1, IFInstr<=imem_rdata, IFPC<=rsp_pc, de_pc<=rsp_pc.
- In every other case: IFValid<=0, IFInstr<=NOP_INSTR, IFPC holds, de_pc holds.
- IFFlush without redirect squashes only the delivered instruction; fetch continues sequentially.
- IFFlush held for several cycles (branch shadow) squashes every delivery in those cycles.
- imem_ready=0: fetch_pc and imem_addr are held stable and imem_req stays 1. A redirect during the stall changes imem_addr next cycle. No drop is set because nothing was accepted.
- imem_rvalid without pending: ignored and flagged by an assertion.
- BranchRedirect and IFFlushBack in the same cycle: the branch wins and de_pc is not refetched.
- rst asserted mid-operation: all state returns immediately to reset values. Any in-flight response arriving after rst falls is ignored because pending=0.

Decomposition:
- Shared package (pipeline package used by all stages):
  - XLEN, RESET_PC and NOP_INSTR constants.
  - FSM state enum {BOOT, FETCH, REDIRECT}.
  - IF/DE payload struct {valid, pc, instr}.
- One sub-module, if_pc_gen: the combinational next-PC priority mux plus the fetch_pc register.
- The FSM, drop/pending tracking and IF/DE register stay in if_fetch_stage.

Test Plan:
- Reset release, imem_ready=1, memory returns addr-tagged words -> imem_addr 0x0,0x4,0x8 on consecutive cycles. IFValid first high 3 cycles after rst falls, with IFPC=0x0 and IFInstr=mem[0].
- Redirect: BranchRedirect=1 with BranchTarget=0x100 while fetching 0x10 -> next imem_addr=0x100. The 0x10/0x14 responses are never IFValid. The next IFValid carries IFPC=0x100.
- IFFlush held 3 cycles in steady flow -> 3 consecutive IFValid=0 with IFInstr=0x00000013, then sequential PCs resume with no gap in imem_addr.
- IFFlushBack while de_pc=0x20 -> the 0x24 delivery is dropped, imem_addr returns to 0x20, and the next IFValid shows IFPC=0x20 then 0x24.
- imem_ready=0 for 4 cycles at 0x40, with BranchRedirect to 0x80 in stall cycle 2 -> imem_addr holds 0x40, then 0x80. No spurious IFValid. First delivery is IFPC=0x80.
- Simultaneous BranchRedirect(0x200)+IFFlushBack; rst pulsed mid-stream -> fetch goes to 0x200. After rst, outputs equal reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Pipeline-wide constants and types shared by the fetch stage and its consumers.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifde_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one outstanding request, fixed one-cycle response.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_pc_gen.sv
// Fetch PC register with its next-PC priority mux (branch, refetch, sequential, hold).
module if_pc_gen
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_PC = RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            flush_back_i,
  input  logic [XLEN-1:0] de_pc_i,
  input  logic            accept_i,
  output logic [XLEN-1:0] fetch_pc_o
);

  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_i) begin
      fetch_pc_d = branch_target_i;
    end else if (flush_back_i) begin
      fetch_pc_d = de_pc_i;
    end else if (accept_i) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= BOOT_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: request FSM, in-flight/drop tracking and the IF/DE register.
// BOOT: idle cycle after reset | FETCH: sequential fetch | REDIRECT: first fetch at a new PC
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = if_fetch_stage_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              IFFlush,
  input  logic              IFFlushBack,
  input  logic              BranchRedirect,
  input  logic [XLEN-1:0]   BranchTarget,
  if_fetch_stage_if.master  imem,
  output logic              IFValid,
  output logic [XLEN-1:0]   IFPC,
  output logic [XLEN-1:0]   IFInstr
);

  fetch_state_e    state_q;
  logic            req_q;
  logic            pending_q;
  logic            drop_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] fetch_pc;
  ifde_t           ifde_d;
  ifde_t           ifde_q;

  logic redirect;
  logic accept;
  logic deliver;

  assign redirect = BranchRedirect | IFFlushBack;
  assign accept   = req_q & imem.imem_ready;
  assign deliver  = imem.imem_rvalid & pending_q & ~drop_q & ~IFFlush & ~redirect;

  if_pc_gen #(
    .BOOT_PC (RESET_PC)
  ) u_pc_gen (
    .clk_i           (CLK),
    .rst_i           (rst),
    .branch_i        (BranchRedirect),
    .branch_target_i (BranchTarget),
    .flush_back_i    (IFFlushBack),
    .de_pc_i         (ifde_q.pc),
    .accept_i        (accept),
    .fetch_pc_o      (fetch_pc)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH, REDIRECT: begin
          state_q <= redirect ? REDIRECT : FETCH;
          req_q   <= 1'b1;
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Squashed deliveries present a NOP but keep the last live PC for refetch.
  always_comb begin
    ifde_d = '{valid: 1'b0, pc: ifde_q.pc, instr: NOP_INSTR};
    if (deliver) begin
      ifde_d = '{valid: 1'b1, pc: rsp_pc_q, instr: imem.imem_rdata};
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      rsp_pc_q  <= RESET_PC;
      ifde_q    <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
    end else begin
      pending_q <= accept;
      drop_q    <= accept & redirect;
      if (accept) begin
        rsp_pc_q <= fetch_pc;
      end
      ifde_q <= ifde_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc;
  assign IFValid        = ifde_q.valid;
  assign IFPC           = ifde_q.pc;
  assign IFInstr        = ifde_q.instr;

  a_rvalid_needs_pending : assert property (
    @(posedge CLK) disable iff (rst) imem.imem_rvalid |-> pending_q
  );

endmodule
